cpu_board_io: RTL and testbench

- Board-side I/O controller for the CPU.
- Generates the CPU clock-enable, either as a single step from a debounced push button or as free-run pulses from a programmable divider.
- Latches the CPU result and drives NDIG active-low seven-segment digits with hex patterns.
- Counts issued steps; sits between the board pins (CLK1, BTN, SW, HEX) and the CPU core.

---
 rtl/cpu_board_io.sv | 172 +++++++++++++++++
 tb/tb_cpu_board_io.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_board_io.sv
`default_nettype none
// ============================================================================
// Module   : cpu_board_io
// Brief    : Board I/O for the CPU: debounced single-step / divided free-run
//            clock-enable, step counter and active-low hex display.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0  initial release
// ============================================================================
module cpu_board_io #(
   parameter int NDIG      = 6,
   parameter int DB_CYCLES = 500000,
   parameter int RUN_DIV   = 5000000,
   parameter int CNT_W     = 8
) (
   input  logic                CLK1,
   input  logic                RST,
   input  logic                BTN_STEP,
   input  logic                SW_RUN,
   input  logic                HALT,
   input  logic [4*NDIG-1:0]   DATA_IN,
   output logic                CPU_EN,
   output logic [8*NDIG-1:0]   HEX,
   output logic [CNT_W-1:0]    STEP_CNT
);

   localparam int c_db_w  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam int c_div_w = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

   localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DB_CYCLES - 1);
   localparam logic [c_db_w-1:0]  c_db_one   = c_db_w'(1);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RUN_DIV - 1);
   localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
   localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [8*NDIG-1:0] c_hex_rst =
      ({(8*NDIG){1'b1}} << 8) | (8*NDIG)'(8'hC0);
`else
   localparam logic [8*NDIG-1:0] c_hex_rst = {NDIG{8'hC0}};
`endif

   logic                r_btn_s1, r_btn_s2;
   logic                r_sw_s1, r_sw_s2;
   logic [c_db_w-1:0]   r_db_cnt;
   logic                r_db_level;
   logic                r_press;
   logic                r_mode;
   logic [c_div_w-1:0]  r_div;
   logic [CNT_W-1:0]    r_step_cnt;
   logic [4*NDIG-1:0]   r_disp;
   logic [8*NDIG-1:0]   r_hex;

   logic                w_db_hit;
   logic                w_mode_chg;
   logic                w_cpu_en;
   logic [8*NDIG-1:0]   w_hex_next;

   function automatic logic [7:0] f_seg(input logic [3:0] n);
      case (n)
         4'h0:    f_seg = 8'hC0;
         4'h1:    f_seg = 8'hF9;
         4'h2:    f_seg = 8'hA4;
         4'h3:    f_seg = 8'hB0;
         4'h4:    f_seg = 8'h99;
         4'h5:    f_seg = 8'h92;
         4'h6:    f_seg = 8'h82;
         4'h7:    f_seg = 8'hF8;
         4'h8:    f_seg = 8'h80;
         4'h9:    f_seg = 8'h90;
         4'hA:    f_seg = 8'h88;
         4'hB:    f_seg = 8'h83;
         4'hC:    f_seg = 8'hC6;
         4'hD:    f_seg = 8'hA1;
         4'hE:    f_seg = 8'h86;
         default: f_seg = 8'h8E;
      endcase
   endfunction

   // Button idles high (released), so its synchroniser resets to 1.
   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_btn_s1 <= 1'b1;
         r_btn_s2 <= 1'b1;
         r_sw_s1  <= 1'b0;
         r_sw_s2  <= 1'b0;
      end else begin
         r_btn_s1 <= BTN_STEP;
         r_btn_s2 <= r_btn_s1;
         r_sw_s1  <= SW_RUN;
         r_sw_s2  <= r_sw_s1;
      end
   end

   assign w_db_hit = (r_btn_s2 != r_db_level) && (r_db_cnt == c_db_last);

   // Press flag fires only when the accepted level falls from 1 to 0.
   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_db_cnt   <= '0;
         r_db_level <= 1'b1;
         r_press    <= 1'b0;
      end else begin
         r_press <= w_db_hit & r_db_level;
         if (r_btn_s2 == r_db_level) begin
            r_db_cnt <= '0;
         end else if (w_db_hit) begin
            r_db_level <= r_btn_s2;
            r_db_cnt   <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + c_db_one;
         end
      end
   end

   assign w_mode_chg = (r_sw_s2 != r_mode);

   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_mode <= 1'b0;
         r_div  <= '0;
      end else begin
         r_mode <= r_sw_s2;
         if (w_mode_chg || (r_div == c_div_last)) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + c_div_one;
         end
      end
   end

   // A press seen while halted or in run mode is simply dropped.
   assign w_cpu_en = ~HALT & ~w_mode_chg &
                     (r_mode ? (r_div == c_div_last) : r_press);

   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_step_cnt <= '0;
         r_disp     <= '0;
      end else if (w_cpu_en) begin
         r_step_cnt <= r_step_cnt + c_cnt_one;
         r_disp     <= DATA_IN;
      end
   end

   for (genvar k = 0; k < NDIG; k++) begin : g_digit
      logic [7:0] w_seg;
      assign w_seg = f_seg(r_disp[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 0) begin : g_lsd
         assign w_hex_next[7:0] = w_seg;
      end else begin : g_blank
         assign w_hex_next[8*k +: 8] = (|r_disp[4*NDIG-1:4*k]) ? w_seg : 8'hFF;
      end
`else
      assign w_hex_next[8*k +: 8] = w_seg;
`endif
   end

   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_hex <= c_hex_rst;
      end else begin
         r_hex <= w_hex_next;
      end
   end

   assign CPU_EN   = w_cpu_en;
   assign HEX      = r_hex;
   assign STEP_CNT = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_board_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_board_io
// Brief    : Scoreboard bench for cpu_board_io (NDIG=2, DB_CYCLES=4,
//            RUN_DIV=8, CNT_W=4); honours LEADING_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_board_io;

   localparam int NDIG      = 2;
   localparam int DB_CYCLES = 4;
   localparam int RUN_DIV   = 8;
   localparam int CNT_W     = 4;

   logic                CLK1 = 1'b0;
   logic                RST;
   logic                BTN_STEP;
   logic                SW_RUN;
   logic                HALT;
   logic [4*NDIG-1:0]   DATA_IN;
   logic                CPU_EN;
   logic [8*NDIG-1:0]   HEX;
   logic [CNT_W-1:0]    STEP_CNT;

   cpu_board_io #(
      .NDIG(NDIG), .DB_CYCLES(DB_CYCLES), .RUN_DIV(RUN_DIV), .CNT_W(CNT_W)
   ) dut (
      .CLK1(CLK1), .RST(RST), .BTN_STEP(BTN_STEP), .SW_RUN(SW_RUN),
      .HALT(HALT), .DATA_IN(DATA_IN), .CPU_EN(CPU_EN), .HEX(HEX),
      .STEP_CNT(STEP_CNT)
   );

   always #5 CLK1 = ~CLK1;

   typedef struct {
      int               cyc;      // -1: arrival cycle not checked
      logic [CNT_W-1:0] cnt;
      logic [15:0]      hex_prev;
      logic [15:0]      hex;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             mon_e;
   int               cyc = 0;
   int               npulses = 0;
   int               n_chk = 0;
   int               n_pass = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   logic [15:0]      shown;
   logic [7:0]       pats [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                   8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                   8'hC6, 8'hA1, 8'h86, 8'h8E};

   always @(posedge CLK1) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [15:0] f_hex(input logic [7:0] v);
      logic [7:0] hi, lo;
      hi = pats[v[7:4]];
      lo = pats[v[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
      if (v[7:4] == 4'h0) hi = 8'hFF;
`endif
      return {hi, lo};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge CLK1);
      #1;
   endtask

   task automatic push_exp(input int c, input logic [7:0] d);
      exp_t e;
      exp_cnt    = exp_cnt + 1'b1;
      e.cyc      = c;
      e.cnt      = exp_cnt;
      e.hex_prev = shown;
      e.hex      = f_hex(d);
      shown      = e.hex;
      exp_q.push_back(e);
   endtask

   task automatic wait_pulses(input int target, input int budget);
      int k = 0;
      while (npulses < target && k < budget) begin
         tick(1);
         k++;
      end
      if (npulses < target) chk("pulse_timeout", 64'(npulses), 64'(target));
   endtask

   task automatic press(input int len);
      BTN_STEP = 1'b0;
      tick(len);
      BTN_STEP = 1'b1;
   endtask

   task automatic run_session(input int n, input logic [7:0] d);
      int t, base;
      DATA_IN = d;
      base    = npulses;
      t       = cyc;
      SW_RUN  = 1'b1;
      for (int j = 0; j < n; j++) push_exp(t + 2 + RUN_DIV * (j + 1), d);
      wait_pulses(base + n, RUN_DIV * (n + 2) + 10);
      SW_RUN = 1'b0;
      tick(30);
      chk("run_stop", 64'(npulses), 64'(base + n));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every CPU_EN pulse consumes one scoreboard entry.
   initial begin
      forever begin
         @(negedge CLK1);
         if (!RST && CPU_EN) begin
            npulses++;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.cyc >= 0) chk("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
               @(negedge CLK1);
               chk("step_cnt", 64'(STEP_CNT), 64'(mon_e.cnt));
               chk("hex_hold", 64'(HEX), 64'(mon_e.hex_prev));
               @(negedge CLK1);
               chk("hex_update", 64'(HEX), 64'(mon_e.hex));
            end
         end
      end
   end

   initial begin
      int t, h, base, j, pushed;
      logic [CNT_W-1:0] cnt_frozen;

      RST = 1'b1; BTN_STEP = 1'b1; SW_RUN = 1'b0; HALT = 1'b0; DATA_IN = '0;
      shown = f_hex(8'h00);
      tick(3);
      chk("rst_cpu_en", 64'(CPU_EN), 64'd0);
      chk("rst_step_cnt", 64'(STEP_CNT), 64'd0);
      chk("rst_hex", 64'(HEX), 64'(f_hex(8'h00)));
      RST = 1'b0;
      tick(5);

      // Glitch shorter than the debounce window
      press(3);
      tick(15);
      chk("glitch_no_pulse", 64'(npulses), 64'd0);

      // Accepted press, held well past debounce
      DATA_IN = 8'h3A;
      push_exp(-1, 8'h3A);
      press(10);
      wait_pulses(1, 40);
      tick(15);
      chk("hold_one_pulse", 64'(npulses), 64'd1);

      DATA_IN = 8'h05;
      push_exp(-1, 8'h05);
      press(10);
      wait_pulses(2, 40);
      tick(5);
      DATA_IN = 8'hFF;
      tick(10);
      chk("no_sample", 64'(HEX), 64'(f_hex(8'h05)));

      // Press while halted is discarded
      HALT = 1'b1;
      press(10);
      tick(10);
      HALT = 1'b0;
      tick(15);
      chk("halt_press_dropped", 64'(npulses), 64'd2);

      // Run mode with an ignored press, then a HALT window
      DATA_IN = 8'h00;
      base    = npulses;
      t       = cyc;
      SW_RUN  = 1'b1;
      for (int k = 0; k < 3; k++) push_exp(t + 2 + RUN_DIV * (k + 1), 8'h00);
      press(10);
      wait_pulses(base + 3, 60);
      h = cyc;
      HALT = 1'b1;
      cnt_frozen = exp_cnt;
      pushed = 0;
      j = 3;
      while (pushed < 2) begin
         if (!((t + 2 + RUN_DIV * (j + 1)) >= h && (t + 2 + RUN_DIV * (j + 1)) <= h + 19)) begin
            push_exp(t + 2 + RUN_DIV * (j + 1), 8'h00);
            pushed++;
         end
         j++;
      end
      tick(20);
      chk("halt_no_pulse", 64'(npulses), 64'(base + 3));
      chk("halt_cnt_frozen", 64'(STEP_CNT), 64'(cnt_frozen));
      HALT = 1'b0;
      wait_pulses(base + 5, 40);
      SW_RUN = 1'b0;
      tick(30);
      chk("run_stop_a", 64'(npulses), 64'(base + 5));
      chk("queue_empty_a", 64'(exp_q.size()), 64'd0);

      // Ten more pulses: 17 in total wraps a 4-bit counter to 1
      run_session(10, 8'hA7);
      chk("wrap_cnt", 64'(STEP_CNT), 64'd1);

      // Reset in the middle of a debounce
      BTN_STEP = 1'b0;
      tick(3);
      RST = 1'b1;
      #2;
      chk("rst_mid_cpu_en", 64'(CPU_EN), 64'd0);
      chk("rst_mid_step_cnt", 64'(STEP_CNT), 64'd0);
      chk("rst_mid_hex", 64'(HEX), 64'(f_hex(8'h00)));
      BTN_STEP = 1'b1;
      tick(2);
      RST = 1'b0;
      shown = f_hex(8'h00);
      tick(20);
      chk("rst_mid_no_pulse", 64'(npulses), 64'd17);
      chk("rst_mid_cnt_hold", 64'(STEP_CNT), 64'd0);
      chk("rst_mid_hex_hold", 64'(HEX), 64'(f_hex(8'h00)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
